// File: rtl/hw_stack.sv
// Parametrised LIFO stack with registered top, sticky error flags, replace-top and a random peek port.
// Latency: push/pop/peek results appear 1 cycle after the sampling edge.
// Backpressure: none; one command set is accepted every cycle, overflowing pushes and empty pops are dropped and flagged.
module hw_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err,
    input  logic             peek_en,
    input  logic [AW-1:0]    peek_off,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_TWO  = AW'(2);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             pvalid_q, pvalid_d;

    logic             is_empty, is_full;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_idx, below_idx, peek_idx;
    logic             ovf_set, unf_set;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Index arithmetic wraps modulo DEPTH, so count == DEPTH still maps top to DEPTH-1.
    assign top_idx   = count_q[AW-1:0] - IDX_ONE;
    assign below_idx = count_q[AW-1:0] - IDX_TWO;
    assign peek_idx  = top_idx - peek_off;

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (push && pop && !is_empty) begin
            // Replace-top: depth unchanged, so legal even when full.
            wr_en   = 1'b1;
            wr_addr = top_idx;
            top_d   = din;
        end else if (push) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                wr_addr = count_q[AW-1:0];
                count_d = count_q + CNT_ONE;
                top_d   = din;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (pop) begin
            if (!is_empty) begin
                count_d = count_q - CNT_ONE;
                top_d   = (count_q >= CNT_TWO) ? mem[below_idx] : '0;
            end else begin
                unf_set = 1'b1;
            end
        end

        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);

        pvalid_d = 1'b0;
        pdata_d  = pdata_q;
        if (peek_en) begin
            if ({1'b0, peek_off} < count_q) begin
                pdata_d  = mem[peek_idx];
                pvalid_d = 1'b1;
            end else begin
                pdata_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            top_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            top_q    <= top_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign top        = top_q;
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign peek_data  = pdata_q;
    assign peek_valid = pvalid_q;

endmodule

// File: tb/tb_hw_stack.sv
// Bench for hw_stack: directed scenarios plus random traffic, scored against a queue-based stack model.
module tb_hw_stack;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          push, pop, clr_err, peek_en;
    logic [W-1:0]  din;
    logic [AW-1:0] peek_off;
    logic [W-1:0]  top, peek_data;
    logic [AW:0]   count;
    logic          empty, full, overflow, underflow, peek_valid;

    hw_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(din),
        .top(top), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
        .peek_en(peek_en), .peek_off(peek_off),
        .peek_data(peek_data), .peek_valid(peek_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int top; int cnt; bit emp; bit ful; bit ovf; bit unf; int pd; bit pv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: stack as a queue, back = top of stack.
    int stk[$];
    bit m_ovf, m_unf, m_pv;
    int m_pd;

    event sample_ev;
    always @(negedge clk) -> sample_ev;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, req);
        end
    endtask

    always @(sample_ev) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("top",        int'(top),        e.top);
            chk("count",      int'(count),      e.cnt);
            chk("empty",      int'(empty),      int'(e.emp));
            chk("full",       int'(full),       int'(e.ful));
            chk("overflow",   int'(overflow),   int'(e.ovf));
            chk("underflow",  int'(underflow),  int'(e.unf));
            chk("peek_data",  int'(peek_data),  e.pd);
            chk("peek_valid", int'(peek_valid), int'(e.pv));
        end
    end

    function automatic void model_reset();
        stk.delete();
        m_ovf = 0; m_unf = 0; m_pv = 0; m_pd = 0;
    endfunction

    function automatic void snap();
        exp_t e;
        e.cnt = stk.size();
        e.top = (stk.size() > 0) ? stk[stk.size()-1] : 0;
        e.emp = (stk.size() == 0);
        e.ful = (stk.size() == D);
        e.ovf = m_ovf; e.unf = m_unf; e.pd = m_pd; e.pv = m_pv;
        exp_q.push_back(e);
    endfunction

    function automatic void model_edge(input bit pu, input bit po, input int d,
                                       input bit pe, input int off, input bit clr);
        int  n;
        bit  os, us;
        n  = stk.size();
        os = 0; us = 0;
        if (pe) begin
            if (off < n) begin m_pd = stk[n-1-off]; m_pv = 1; end
            else begin m_pd = 0; m_pv = 0; end
        end else begin
            m_pv = 0;
        end
        if (pu && po && n > 0)      stk[n-1] = d;
        else if (pu) begin
            if (n < D) stk.push_back(d);
            else       os = 1;
        end else if (po) begin
            if (n > 0) void'(stk.pop_back());
            else       us = 1;
        end
        m_ovf = os | (m_ovf & !clr);
        m_unf = us | (m_unf & !clr);
    endfunction

    task automatic step(input bit pu, input bit po, input int d,
                        input bit pe, input int off, input bit clr);
        push = pu; pop = po; din = W'(d); peek_en = pe; peek_off = AW'(off); clr_err = clr;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge(pu, po, d, pe, off, clr);
        snap();
        #1;
    endtask

    task automatic do_push(input int d); step(1, 0, d, 0, 0, 0); endtask
    task automatic do_pop();             step(0, 1, 0, 0, 0, 0); endtask
    task automatic do_clr();             step(0, 0, 0, 0, 0, 1); endtask
    task automatic do_peek(input int o); step(0, 0, 0, 1, o, 0); endtask
    task automatic drain();
        for (int i = 0; i < D; i++) do_pop();
        do_clr();
    endtask

    initial begin
        push = 0; pop = 0; din = '0; clr_err = 0; peek_en = 0; peek_off = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        snap();
        -> sample_ev;
        #1 reset_n = 1'b1;

        // Basic push/pop ordering
        do_push('h11); do_push('h22); do_push('h33);
        do_pop(); do_pop(); do_pop();

        // Fill, overflow, sticky flag, clear
        do_push(1); do_push(2); do_push(3); do_push(4);
        do_push(5);
        do_pop();
        do_clr();
        drain();

        // Underflow and clear-vs-set priority
        do_pop();
        step(0, 1, 0, 0, 0, 1);
        do_clr();

        // Replace-top in the middle, when empty, and when full
        do_push('h11); do_push('h22);
        step(1, 1, 'hAB, 0, 0, 0);
        do_pop();
        do_pop();
        step(1, 1, 'h5, 0, 0, 0);
        do_push(6); do_push(7); do_push(8);
        step(1, 1, 'h99, 0, 0, 0);
        drain();

        // Peek in range, out of range, concurrent with push, then hold
        do_push('h11); do_push('h22); do_push('h33);
        do_peek(0);
        do_peek(2);
        do_peek(3);
        do_peek(1);
        step(1, 0, 'h44, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 'h55, 1, 3, 0);
        drain();

        // Asynchronous reset between edges with commands presented
        for (int i = 0; i < 8; i++) do_push(i + 'h100);
        step(0, 0, 0, 1, 1, 0);
        @(negedge clk); #1;
        reset_n = 1'b0; push = 1; din = 'h3C;
        #1;
        model_reset();
        snap();
        -> sample_ev;
        #1;
        step(1, 0, 'h3D, 1, 0, 0);
        reset_n = 1'b1;
        do_push('h7);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4, int'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, D-1), $urandom_range(0, 15) == 0);
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
